// File: rtl/apcpu_pkg.sv
// Shared APCPU definitions: MenagePC command codes, fetch/decode states and
// instruction word field layout.
package apcpu_pkg;

    localparam logic [2:0] MPC_HOLD = 3'd0;
    localparam logic [2:0] MPC_INC  = 3'd1;
    localparam logic [2:0] MPC_LOAD = 3'd2;
    localparam logic [2:0] MPC_SKIP = 3'd3;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 24;
    localparam int unsigned IMM_W   = 24;

    localparam logic [7:0] ALU_NOP = 8'd0;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_ISSUE = 1'b1
    } fd_state_e;

    // Codes 4-7 are reserved.
    function automatic logic is_reserved_cmd(input logic [2:0] cmd);
        return cmd[2];
    endfunction

    function automatic logic is_retire_cmd(input logic [2:0] cmd);
        return !cmd[2] && (cmd != MPC_HOLD);
    endfunction

endpackage

// File: rtl/apcpu_pc_unit.sv
// Program counter register with hold/increment/load/skip selection.
// Arithmetic wraps modulo 2^ADDR_W.
module apcpu_pc_unit
    import apcpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              upd_i,
    input  logic [2:0]        cmd_i,
    input  logic [ADDR_W-1:0] pc_set_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (upd_i) begin
            unique case (cmd_i)
                MPC_HOLD: pc_d = pc_q;
                MPC_INC:  pc_d = pc_q + ADDR_W'(1);
                MPC_LOAD: pc_d = pc_set_i;
                MPC_SKIP: pc_d = pc_q + ADDR_W'(2);
                default:  pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/apcpu_fetch_decode.sv
// APCPU fetch/decode stage: fetches a word at PC, presents opcode/immediate to the
// ALU until MenagePC retires it. Optional fetch watchdog under FETCH_TIMEOUT_EN.
module apcpu_fetch_decode
    import apcpu_pkg::*;
#(
    parameter int unsigned       ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] RESET_PC       = '0,
    parameter int unsigned       TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] InstrAddr,
    output logic              InstrReq,
    input  logic [31:0]       InstrData,
    input  logic              InstrValid,
    input  logic [2:0]        MenagePC,
    input  logic [ADDR_W-1:0] PCSet,
    output logic [7:0]        ALU_Sel,
    output logic [IMM_W-1:0]  DecoderData,
    output logic              OpValid,
    output logic [ADDR_W-1:0] PC,
    output logic [31:0]       RetiredCount,
    output logic              IllegalCmd,
    output logic              FetchFault
);

    fd_state_e         state_q, state_d;
    logic              req_q, req_d;
    logic [7:0]        sel_q, sel_d;
    logic [IMM_W-1:0]  imm_q, imm_d;
    logic              opv_q, opv_d;
    logic [31:0]       ret_q, ret_d;
    logic              ill_q, ill_d;
    logic              pc_upd;
    logic              timeout_hit;
    logic [ADDR_W-1:0] pc;

    apcpu_pc_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk_i    (clk),
        .rst_ni   (rst),
        .upd_i    (pc_upd),
        .cmd_i    (MenagePC),
        .pc_set_i (PCSet),
        .pc_o     (pc)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        sel_d   = sel_q;
        imm_d   = imm_q;
        opv_d   = opv_q;
        ret_d   = ret_q;
        ill_d   = 1'b0;
        pc_upd  = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                // InstrValid only counts while our request is visible to memory.
                if (req_q && InstrValid) begin
                    sel_d   = InstrData[OPC_MSB:OPC_LSB];
                    imm_d   = InstrData[IMM_W-1:0];
                    opv_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_ISSUE;
                end else if (timeout_hit) begin
                    req_d = 1'b0;
                end else begin
                    req_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                req_d = 1'b0;
                if (is_reserved_cmd(MenagePC)) begin
                    ill_d = 1'b1;
                end else if (is_retire_cmd(MenagePC)) begin
                    pc_upd  = 1'b1;
                    ret_d   = ret_q + 32'd1;
                    sel_d   = ALU_NOP;
                    imm_d   = '0;
                    opv_d   = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FETCH;
            req_q   <= 1'b0;
            sel_q   <= ALU_NOP;
            imm_q   <= '0;
            opv_q   <= 1'b0;
            ret_q   <= 32'd0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            sel_q   <= sel_d;
            imm_q   <= imm_d;
            opv_q   <= opv_d;
            ret_q   <= ret_d;
            ill_q   <= ill_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CntW =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            fault_q;

    // Counts cycles the request has been outstanding; a hit drops the request
    // for one cycle and restarts the count.
    always_comb begin
        tmo_cnt_d   = '0;
        timeout_hit = 1'b0;
        if ((state_q == ST_FETCH) && req_q && !InstrValid) begin
            if (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                timeout_hit = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            fault_q   <= timeout_hit;
        end
    end

    assign FetchFault = fault_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign FetchFault         = 1'b0;
`endif

    assign InstrAddr    = pc;
    assign PC           = pc;
    assign InstrReq     = req_q;
    assign ALU_Sel      = sel_q;
    assign DecoderData  = imm_q;
    assign OpValid      = opv_q;
    assign RetiredCount = ret_q;
    assign IllegalCmd   = ill_q;

endmodule

// File: tb/tb_apcpu_fetch_decode.sv
// Self-checking bench for apcpu_fetch_decode; exercises the FETCH_TIMEOUT_EN
// watchdog when that macro is defined.
module tb_apcpu_fetch_decode;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] InstrAddr;
    logic        InstrReq;
    logic [31:0] InstrData = '0;
    logic        InstrValid = 1'b0;
    logic [2:0]  MenagePC = 3'd0;
    logic [31:0] PCSet = '0;
    logic [7:0]  ALU_Sel;
    logic [23:0] DecoderData;
    logic        OpValid;
    logic [31:0] PC;
    logic [31:0] RetiredCount;
    logic        IllegalCmd;
    logic        FetchFault;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_pc     = 32'd0;
    logic [31:0] m_ret    = 32'd0;
    logic [31:0] req_addr;

    apcpu_fetch_decode #(
        .ADDR_W         (32),
        .RESET_PC       (32'd0),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .InstrAddr    (InstrAddr),
        .InstrReq     (InstrReq),
        .InstrData    (InstrData),
        .InstrValid   (InstrValid),
        .MenagePC     (MenagePC),
        .PCSet        (PCSet),
        .ALU_Sel      (ALU_Sel),
        .DecoderData  (DecoderData),
        .OpValid      (OpValid),
        .PC           (PC),
        .RetiredCount (RetiredCount),
        .IllegalCmd   (IllegalCmd),
        .FetchFault   (FetchFault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference PC rule straight from the command definitions.
    function automatic logic [31:0] model_pc(input logic [31:0] pc, input logic [2:0] cmd,
                                             input logic [31:0] tgt);
        if (cmd == 3'd1) return pc + 32'd1;
        if (cmd == 3'd2) return tgt;
        if (cmd == 3'd3) return pc + 32'd2;
        return pc;
    endfunction

    // Memory side: wait for a request, stall, then return one word.
    task automatic do_fetch(input logic [31:0] word, input int unsigned waits, output bit ok);
        int guard = 0;
        ok = 1'b0;
        while (InstrReq !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        if (InstrReq !== 1'b1) return;
        req_addr = InstrAddr;
        repeat (waits) tick();
        InstrData  = word;
        InstrValid = 1'b1;
        tick();
        InstrValid = 1'b0;
        InstrData  = $urandom();
        ok = 1'b1;
    endtask

    // ALU side: issue one command for a single cycle.
    task automatic do_cmd(input logic [2:0] cmd, input logic [31:0] tgt);
        MenagePC = cmd;
        PCSet    = tgt;
        tick();
        MenagePC = 3'd0;
        if (cmd >= 3'd1 && cmd <= 3'd3) begin
            m_pc  = model_pc(m_pc, cmd, tgt);
            m_ret = m_ret + 32'd1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({InstrReq, OpValid, ALU_Sel, DecoderData, PC, RetiredCount, IllegalCmd, FetchFault}
            !== {1'b0, 1'b0, 8'h00, 24'h0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: req=%b opv=%b sel=%h imm=%h pc=%h ret=%h ill=%b ff=%b",
                     InstrReq, OpValid, ALU_Sel, DecoderData, PC, RetiredCount, IllegalCmd,
                     FetchFault);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if ({InstrReq, InstrAddr} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_first_req: req=%b addr=%h want 1/0", InstrReq, InstrAddr);
        end
    endtask

    task automatic test_first_fetch();
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({InstrReq, OpValid, InstrAddr} !== {1'b1, 1'b0, 32'h0}) begin
                n_fail++;
                $display("FAIL first_wait%0d: req=%b opv=%b addr=%h want 1/0/0", i, InstrReq,
                         OpValid, InstrAddr);
            end
        end
        InstrData  = 32'h0100_00FA;
        InstrValid = 1'b1;
        tick();
        InstrValid = 1'b0;
        n_checks++;
        if ({ALU_Sel, DecoderData, OpValid, InstrReq} !== {8'h01, 24'd250, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL first_issue: sel=%h imm=%0d opv=%b req=%b want 01/250/1/0",
                     ALU_Sel, DecoderData, OpValid, InstrReq);
        end
    endtask

    task automatic test_hold_inc();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({ALU_Sel, DecoderData, OpValid, PC, InstrReq, RetiredCount}
                !== {8'h01, 24'd250, 1'b1, 32'h0, 1'b0, 32'h0}) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: sel=%h imm=%h opv=%b pc=%h req=%b ret=%h", i,
                         ALU_Sel, DecoderData, OpValid, PC, InstrReq, RetiredCount);
            end
        end
        do_cmd(3'd1, 32'h0);
        n_checks++;
        if ({PC, RetiredCount, ALU_Sel, OpValid, InstrReq}
            !== {32'h1, 32'h1, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL inc_retire: pc=%h ret=%h sel=%h opv=%b req=%b want 1/1/00/0/0",
                     PC, RetiredCount, ALU_Sel, OpValid, InstrReq);
        end
        tick();
        n_checks++;
        if ({InstrReq, InstrAddr} !== {1'b1, 32'h1}) begin
            n_fail++;
            $display("FAIL inc_refetch: req=%b addr=%h want 1/00000001", InstrReq, InstrAddr);
        end
    endtask

    task automatic test_load_skip();
        bit ok;
        do_fetch(32'hAB12_3456, 1, ok);
        do_cmd(3'd2, 32'h0001_E782);
        do_fetch(32'h0200_0000, 0, ok);
        n_checks++;
        if (!ok || req_addr !== 32'h0001_E782) begin
            n_fail++;
            $display("FAIL load_addr: ok=%b addr=%h want 0001e782", ok, req_addr);
        end
        do_cmd(3'd2, 32'hFFFF_FFFF);
        do_fetch(32'h0300_0001, 2, ok);
        n_checks++;
        if (!ok || req_addr !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL load_top_addr: ok=%b addr=%h want ffffffff", ok, req_addr);
        end
        do_cmd(3'd3, 32'h0);
        n_checks++;
        if ({PC, RetiredCount} !== {32'h1, m_ret}) begin
            n_fail++;
            $display("FAIL skip_wrap: pc=%h ret=%h want 00000001/%h", PC, RetiredCount, m_ret);
        end
    endtask

    task automatic test_illegal();
        bit ok;
        do_fetch(32'h7F00_1234, 0, ok);
        InstrData  = 32'hEEEE_EEEE;
        InstrValid = 1'b1;
        tick();
        tick();
        InstrValid = 1'b0;
        n_checks++;
        if ({ALU_Sel, DecoderData, OpValid, InstrReq} !== {8'h7F, 24'h001234, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL issue_ignores_valid: sel=%h imm=%h opv=%b req=%b", ALU_Sel,
                     DecoderData, OpValid, InstrReq);
        end
        do_cmd(3'd5, 32'h0);
        n_checks++;
        if ({IllegalCmd, PC, OpValid, ALU_Sel, RetiredCount}
            !== {1'b1, m_pc, 1'b1, 8'h7F, m_ret}) begin
            n_fail++;
            $display("FAIL illegal_pulse: ill=%b pc=%h opv=%b sel=%h ret=%h", IllegalCmd, PC,
                     OpValid, ALU_Sel, RetiredCount);
        end
        tick();
        n_checks++;
        if ({IllegalCmd, OpValid} !== {1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL illegal_one_cycle: ill=%b opv=%b want 0/1", IllegalCmd, OpValid);
        end
        do_cmd(3'd1, 32'h0);
    endtask

    task automatic test_async_reset();
        bit ok;
        do_fetch(32'h0400_0000, 0, ok);
        do_cmd(3'd2, 32'h0000_0040);
        tick();
        n_checks++;
        if ({InstrReq, InstrAddr} !== {1'b1, 32'h40}) begin
            n_fail++;
            $display("FAIL pre_reset_req: req=%b addr=%h want 1/00000040", InstrReq, InstrAddr);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({InstrReq, PC, InstrAddr, RetiredCount} !== {1'b0, 32'h0, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL async_reset: req=%b pc=%h addr=%h ret=%h want 0/0/0/0", InstrReq, PC,
                     InstrAddr, RetiredCount);
        end
        m_pc  = 32'h0;
        m_ret = 32'h0;
        tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({InstrReq, InstrAddr} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL refetch_after_reset: req=%b addr=%h want 1/0", InstrReq, InstrAddr);
        end
    endtask

    task automatic test_timeout();
        bit          ok;
        logic [31:0] word;
        int          guard = 0;
        while (InstrReq !== 1'b1 && guard < 10) begin
            tick();
            guard++;
        end
`ifdef FETCH_TIMEOUT_EN
        // Request stays up TMO cycles, then a one-cycle drop with FetchFault.
        for (int c = 1; c <= 2 * int'(TMO + 1); c++) begin
            logic exp_req;
            tick();
            exp_req = ((c % int'(TMO + 1)) != int'(TMO));
            n_checks++;
            if ({InstrReq, FetchFault, InstrAddr} !== {exp_req, ~exp_req, m_pc}) begin
                n_fail++;
                $display("FAIL timeout_c%0d: req=%b ff=%b addr=%h want %b/%b/%h", c, InstrReq,
                         FetchFault, InstrAddr, exp_req, ~exp_req, m_pc);
            end
        end
`else
        for (int c = 1; c <= 20; c++) begin
            tick();
            n_checks++;
            if ({InstrReq, FetchFault, InstrAddr} !== {1'b1, 1'b0, m_pc}) begin
                n_fail++;
                $display("FAIL wait_forever_c%0d: req=%b ff=%b addr=%h", c, InstrReq,
                         FetchFault, InstrAddr);
            end
        end
`endif
        word = $urandom();
        do_fetch(word, 0, ok);
        n_checks++;
        if (!ok || {ALU_Sel, DecoderData, OpValid, FetchFault} !== {word, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL timeout_then_issue: ok=%b sel=%h imm=%h opv=%b ff=%b want %h", ok,
                     ALU_Sel, DecoderData, OpValid, FetchFault, word);
        end
        do_cmd(3'd1, 32'h0);
    endtask

    task automatic test_back_to_back();
        bit          ok;
        logic [31:0] word;
        logic [31:0] tgt;
        logic [2:0]  cmd;
        int unsigned r;
        for (int n = 0; n < 40; n++) begin
            word = $urandom();
            do_fetch(word, $urandom_range(0, 3), ok);
            n_checks++;
            if (!ok || req_addr !== m_pc
                || {ALU_Sel, DecoderData, OpValid, InstrReq} !== {word, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL b2b_fetch%0d: ok=%b addr=%h sel=%h imm=%h opv=%b want %h @%h", n,
                         ok, req_addr, ALU_Sel, DecoderData, OpValid, word, m_pc);
            end
            repeat ($urandom_range(0, 2)) tick();
            r = $urandom_range(0, 9);
            if (r >= 8) begin
                do_cmd(3'(4 + $urandom_range(0, 3)), 32'h0);
                n_checks++;
                if ({IllegalCmd, PC, OpValid} !== {1'b1, m_pc, 1'b1}) begin
                    n_fail++;
                    $display("FAIL b2b_illegal%0d: ill=%b pc=%h opv=%b want 1/%h/1", n,
                             IllegalCmd, PC, OpValid, m_pc);
                end
            end
            cmd = (r < 4) ? 3'd1 : (r < 6) ? 3'd2 : (r < 8) ? 3'd3 : 3'd1;
            tgt = ($urandom_range(0, 1) == 0) ? $urandom() : 32'hFFFF_FFFF - $urandom_range(0, 1);
            do_cmd(cmd, tgt);
            n_checks++;
            if ({PC, RetiredCount, ALU_Sel, DecoderData, OpValid, InstrReq, IllegalCmd}
                !== {m_pc, m_ret, 8'h00, 24'h0, 1'b0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL b2b_retire%0d: pc=%h ret=%h sel=%h opv=%b req=%b want %h/%h", n,
                         PC, RetiredCount, ALU_Sel, OpValid, InstrReq, m_pc, m_ret);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_hold_inc();
        m_pc  = 32'h1;
        m_ret = 32'h1;
        test_load_skip();
        test_illegal();
        test_async_reset();
        test_timeout();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apcpu_fetch_decode.md
Name: apcpu_fetch_decode

Overview:
Instruction fetch/decode stage directly upstream of the APCPU ALU. Owns the program counter and fetches 32-bit instruction words over a request/valid handshake. Splits each word into the ALU operation select (ALU_Sel) and the 24-bit immediate (DecoderData). Holds both stable until the ALU returns its MenagePC command, then updates the PC and fetches the next word.

Parameters:
ADDR_W, 32, PC / instruction address width
RESET_PC, 0, PC value loaded on reset
TIMEOUT_CYCLES, 255, fetch watchdog limit (used only with FETCH_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
InstrAddr  out  ADDR_W  fetch address (equals PC)
InstrReq  out  1  fetch request, held until InstrValid
InstrData  in  32  instruction word from memory
InstrValid  in  1  InstrData valid; sampled only while InstrReq=1
MenagePC  in  3  ALU PC command: 0 hold, 1 PC+1, 2 load PCSet, 3 PC+2 (skip), 4-7 reserved
PCSet  in  ADDR_W  jump target for MenagePC=2
ALU_Sel  out  8  opcode to ALU (0 = NOP when no op issued)
DecoderData  out  24  immediate to ALU
OpValid  out  1  ALU_Sel/DecoderData hold a live instruction
PC  out  ADDR_W  current program counter
RetiredCount  out  32  instructions retired, wraps
IllegalCmd  out  1  one-cycle pulse on reserved MenagePC
FetchFault  out  1  one-cycle pulse on fetch timeout (feature only)

Behaviour:
- Reset (rst=0, asynchronous): state FETCH, PC=RESET_PC, InstrReq=0, ALU_Sel=0, DecoderData=0, OpValid=0, RetiredCount=0, IllegalCmd=0, FetchFault=0. The first edge after rst deasserts asserts InstrReq.
- All outputs are registered. InstrAddr is driven from PC.
- FETCH state:
  - InstrReq=1.
  - On an edge with InstrValid=1: latch ALU_Sel=InstrData[31:24] and DecoderData=InstrData[23:0], set OpValid=1, drop InstrReq, go to ISSUE. Memory-to-ALU latency is 1 cycle.
  - MenagePC is ignored in this state.
- ISSUE state:
  - InstrReq=0. InstrValid is ignored.
  - MenagePC=0: hold all outputs.
  - MenagePC=1: PC <= PC+1.
  - MenagePC=2: PC <= PCSet.
  - MenagePC=3: PC <= PC+2.
  - For commands 1-3, on the same edge: RetiredCount+1, ALU_Sel=0, DecoderData=0, OpValid=0, go to FETCH. The new request is issued the next cycle, so there is a minimum of 3 cycles per instruction.
  - MenagePC 4-7: PC unchanged, IllegalCmd pulses 1 cycle, stay in ISSUE.
- PC arithmetic is modulo 2^ADDR_W: all-ones+1 gives 0, all-ones+2 gives 1. RetiredCount wraps at 2^32.
- Opcode 0x00 fetched from memory is still issued with OpValid=1; the ALU must return a MenagePC command for it.
- Reset mid-fetch or mid-issue: the request or op is abandoned immediately and the PC returns to RESET_PC.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined: an 8+ bit counter (sized from TIMEOUT_CYCLES) runs while in FETCH and clears on InstrValid or leaving FETCH. When it reaches TIMEOUT_CYCLES with no InstrValid:
  - FetchFault pulses 1 cycle.
  - InstrReq deasserts for exactly 1 cycle and then re-asserts at the same address.
  - The counter restarts.
- Undefined: no counter is built; FetchFault is tied to 0; FETCH waits indefinitely.

Decomposition:
- Shared package apcpu_pkg:
  - MenagePC encodings: MPC_HOLD=0, MPC_INC=1, MPC_LOAD=2, MPC_SKIP=3.
  - State encodings: ST_FETCH, ST_ISSUE.
  - Instruction field slices: OPC_MSB=31, OPC_LSB=24, IMM_W=24.
  - ALU_NOP=8'd0.
- One natural sub-module: apcpu_pc_unit. It holds the PC register with its hold/inc/load/skip mux and wrap arithmetic; the FSM stays in the top.

Test Plan:
1. Reset release, PC=0. Memory returns 0x01_0000FA after 2 wait cycles. Expect InstrReq high at addr 0, then ALU_Sel=1, DecoderData=250, OpValid=1 one cycle after InstrValid.
2. In ISSUE, hold MenagePC=0 for 5 cycles, then apply 1. Expect outputs frozen for the 5 cycles, then PC=1, RetiredCount=1, ALU_Sel=0, and InstrReq high at addr 1 on the following cycle.
3. MenagePC=2 with PCSet=0x0001_E782. Expect next InstrAddr=0x0001_E782. MenagePC=3 at PC=0xFFFF_FFFF: expect PC=0x0000_0001.
4. MenagePC=5 in ISSUE. Expect a 1-cycle IllegalCmd pulse, PC unchanged, OpValid still 1. InstrValid pulsed during ISSUE must be ignored.
5. Assert rst=0 asynchronously mid-FETCH with PC=0x40. Expect InstrReq=0 and PC=RESET_PC without waiting for a clock edge, and a refetch from 0 after release.
6. With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=4, withhold InstrValid. Expect FetchFault pulse plus a 1-cycle InstrReq drop after 4 cycles, repeating until InstrValid arrives; then a normal ISSUE.
